// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan decoder and the matching display driver:
// segment patterns (active-low, bit 0 = a), digit codes, parameter defaults and frame states.
package seg_scan_decoder_pkg;

  localparam int SETTLE_CYCLES_DEFAULT = 4;
  localparam int FRAME_TIMEOUT_DEFAULT = 1_000_000;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_ILLEGAL = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PUBLISH
  } frame_state_e;

  // True when exactly one active-low anode line is driven.
  function automatic logic one_anode_low(input logic [3:0] an);
    return $countones(~an) == 1;
  endfunction

  function automatic logic multi_anode_low(input logic [3:0] an);
    return $countones(~an) > 1;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_decode.sv
// Combinational seven-segment pattern to digit-code decoder.
// Unknown patterns map to the illegal code and raise the illegal flag.
module seg7_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       illegal
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    code    = CODE_ILLEGAL;
    illegal = 1'b0;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four displayed digits from a multiplexed, active-low seven-segment bus.
// Each stable anode dwell captures one digit; a full set of four is published as a frame.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int FRAME_TIMEOUT = FRAME_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        err_clear,
  output logic [15:0] digits,
  output logic        frame_strobe,
  output logic        frame_changed,
  output logic        seg_err,
  output logic        an_err,
  output logic        timeout
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = $clog2(FRAME_TIMEOUT + 1);

  logic [6:0]       seg_s1, seg_s2;
  logic [3:0]       an_s1, an_s2;
  logic [10:0]      prev_bus;
  logic [CNT_W-1:0] settle_cnt;
  logic [TMR_W-1:0] frame_timer;
  logic [3:0]       staging [4];
  logic [15:0]      staging_flat;
  logic [3:0]       mask;
  frame_state_e     state, next_state;

  logic       bus_changed, dwell_done, capture;
  logic [1:0] anode_idx;
  logic [3:0] capture_bit;
  logic [3:0] dec_code;
  logic       dec_illegal;
  logic       publish, discard;

  seg7_decode u_decode (
    .pattern (seg_s2),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  assign bus_changed  = {seg_s2, an_s2} != prev_bus;
  // Fires on the single cycle the stability counter reaches its limit.
  assign dwell_done   = !bus_changed && (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign capture      = dwell_done && one_anode_low(an_s2);
  assign capture_bit  = capture ? (4'b0001 << anode_idx) : 4'b0000;
  assign staging_flat = {staging[3], staging[2], staging[1], staging[0]};

  always_comb begin
    anode_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!an_s2[k]) anode_idx = 2'(k);
    end
  end

  always_comb begin
    next_state = state;
    publish    = 1'b0;
    discard    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (capture || mask != 4'h0) next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (mask == 4'hF) begin
          next_state = ST_PUBLISH;
          publish    = 1'b1;
        end else if (frame_timer == TMR_W'(FRAME_TIMEOUT - 1)) begin
          next_state = ST_IDLE;
          discard    = 1'b1;
        end
      end
      ST_PUBLISH: begin
        // A digit captured on the publish edge already starts the next frame.
        next_state = (capture || mask != 4'h0) ? ST_COLLECT : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1        <= '1;
      seg_s2        <= '1;
      an_s1         <= '1;
      an_s2         <= '1;
      prev_bus      <= '1;
      settle_cnt    <= '0;
      frame_timer   <= '0;
      mask          <= '0;
      state         <= ST_IDLE;
      digits        <= 16'hFFFF;
      frame_strobe  <= 1'b0;
      frame_changed <= 1'b0;
      timeout       <= 1'b0;
      seg_err       <= 1'b0;
      an_err        <= 1'b0;
      // NOTE: the four-entry staging array is reset explicitly; an unwritten slot must read as blank.
      for (int k = 0; k < 4; k++) staging[k] <= CODE_BLANK;
    end else begin
      seg_s1   <= seg;
      seg_s2   <= seg_s1;
      an_s1    <= an;
      an_s2    <= an_s1;
      prev_bus <= {seg_s2, an_s2};

      if (bus_changed)                                settle_cnt <= '0;
      else if (settle_cnt != CNT_W'(SETTLE_CYCLES))  settle_cnt <= settle_cnt + 1'b1;

      if (capture) staging[anode_idx] <= dec_code;

      if (discard)      mask <= 4'h0;
      else if (publish) mask <= capture_bit;
      else              mask <= mask | capture_bit;

      state       <= next_state;
      frame_timer <= (next_state == ST_COLLECT && state == ST_COLLECT) ? frame_timer + 1'b1 : '0;

      frame_strobe  <= publish;
      frame_changed <= publish && (staging_flat != digits);
      if (publish) digits <= staging_flat;
      timeout <= discard;

      // A new error in the same cycle as err_clear keeps the flag set.
      seg_err <= (seg_err & ~err_clear) | (capture & dec_illegal);
      an_err  <= (an_err & ~err_clear) | (dwell_done & multi_anode_low(an_s2));
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: frame capture, repeat frames, glitch rejection,
// anode and segment errors, frame timeout and reset mid-frame.
module tb_seg_scan_decoder;

  localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30, P4 = 7'h19;
  localparam logic [6:0] P5 = 7'h12, P6 = 7'h02, P7 = 7'h78, P8 = 7'h00, P9 = 7'h10;
  localparam logic [6:0] PBLANK = 7'h7F;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err_clear;
  logic [15:0] digits;
  logic        frame_strobe, frame_changed, seg_err, an_err, timeout;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0, changed_cnt = 0, timeout_cnt = 0;
  int s0, c0, t0;

  seg_scan_decoder #(
    .SETTLE_CYCLES (4),
    .FRAME_TIMEOUT (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .seg           (seg),
    .an            (an),
    .err_clear     (err_clear),
    .digits        (digits),
    .frame_strobe  (frame_strobe),
    .frame_changed (frame_changed),
    .seg_err       (seg_err),
    .an_err        (an_err),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_strobe)  strobe_cnt++;
    if (frame_changed) changed_cnt++;
    if (timeout)       timeout_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scan anodes 0..3 with 8-cycle dwells, then idle long enough for publish.
  task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                      input logic [6:0] d2, input logic [6:0] d3);
    dwell(4'b1110, d0, 8);
    dwell(4'b1101, d1, 8);
    dwell(4'b1011, d2, 8);
    dwell(4'b0111, d3, 8);
    dwell(4'b1111, PBLANK, 12);
  endtask

  task automatic mark;
    s0 = strobe_cnt;
    c0 = changed_cnt;
    t0 = timeout_cnt;
  endtask

  initial begin
    reset = 1'b1; seg = PBLANK; an = 4'hF; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_digits", 32'(digits), 32'hFFFF);
    check("rst_strobe", 32'(frame_strobe), 0);
    check("rst_changed", 32'(frame_changed), 0);
    check("rst_seg_err", 32'(seg_err), 0);
    check("rst_an_err", 32'(an_err), 0);
    check("rst_timeout", 32'(timeout), 0);

    // Idle bus: no capture, no error, no timeout.
    mark();
    dwell(4'hF, PBLANK, 120);
    check("idle_timeout", 32'(timeout_cnt - t0), 0);
    check("idle_strobe", 32'(strobe_cnt - s0), 0);
    check("idle_an_err", 32'(an_err), 0);

    mark();
    scan(P1, P2, P3, P4);
    check("scan1_strobe", 32'(strobe_cnt - s0), 1);
    check("scan1_changed", 32'(changed_cnt - c0), 1);
    check("scan1_digits", 32'(digits), 32'h4321);
    check("scan1_seg_err", 32'(seg_err), 0);

    mark();
    scan(P1, P2, P3, P4);
    check("scan2_strobe", 32'(strobe_cnt - s0), 1);
    check("scan2_changed", 32'(changed_cnt - c0), 0);
    check("scan2_digits", 32'(digits), 32'h4321);

    // Short glitch at dwell start must not be captured.
    mark();
    dwell(4'b1110, P8, 2);
    dwell(4'b1110, P1, 6);
    dwell(4'b1101, P5, 8);
    dwell(4'b1011, P6, 8);
    dwell(4'b0111, P7, 8);
    dwell(4'b1111, PBLANK, 12);
    check("glitch_strobe", 32'(strobe_cnt - s0), 1);
    check("glitch_digits", 32'(digits), 32'h7651);
    check("glitch_seg_err", 32'(seg_err), 0);

    // Two anodes low: error, and no capture (so no frame timer, no timeout).
    mark();
    dwell(4'b1100, P1, 10);
    dwell(4'hF, PBLANK, 110);
    check("anerr_set", 32'(an_err), 1);
    check("anerr_timeout", 32'(timeout_cnt - t0), 0);
    check("anerr_strobe", 32'(strobe_cnt - s0), 0);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    check("anerr_clear", 32'(an_err), 0);

    mark();
    scan(P1, P2, 7'h7E, P4);
    check("segerr_strobe", 32'(strobe_cnt - s0), 1);
    check("segerr_digits", 32'(digits), 32'h4E21);
    check("segerr_set", 32'(seg_err), 1);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    check("segerr_clear", 32'(seg_err), 0);

    // Three digits only: timer expires and the partial frame is dropped.
    mark();
    dwell(4'b1110, P8, 8);
    dwell(4'b1101, P9, 8);
    dwell(4'b1011, P0, 8);
    dwell(4'hF, PBLANK, 120);
    check("to_pulse", 32'(timeout_cnt - t0), 1);
    check("to_strobe", 32'(strobe_cnt - s0), 0);
    check("to_digits", 32'(digits), 32'h4E21);

    // Reset mid-frame discards the partial frame silently.
    mark();
    dwell(4'b1110, P3, 8);
    dwell(4'b1101, P3, 8);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_digits", 32'(digits), 32'hFFFF);
    dwell(4'hF, PBLANK, 120);
    check("midrst_strobe", 32'(strobe_cnt - s0), 0);
    check("midrst_timeout", 32'(timeout_cnt - t0), 0);
    check("midrst_digits_hold", 32'(digits), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
